// File: rtl/seg7_pkg.sv
// Shared constants and types for the 4-digit seven-segment scan driver.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam int SEG7_DIGITS = 4;
    localparam logic [6:0] SEG7_BLANK = 7'h7F;
    localparam logic [3:0] WEI_OFF = 4'hF;

    // Index n holds the active-low segment pattern for hex digit n
    localparam logic [15:0][6:0] SEG7_HEX = {
        7'h0E, 7'h06, 7'h21, 7'h46,
        7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19,
        7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef enum logic {
        PH_BLANK,
        PH_ON
    } phase_e;

endpackage

// File: rtl/seg7_hex_decode.sv
// Nibble to active-low seven-segment pattern.
// Purely combinational table lookup.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Look up the segment pattern for the nibble
    always_comb begin
        seg = SEG7_HEX[nibble];
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Tear-free 4-digit hex scan driver with per-slot blanking guard.
// Define SEG7_LZB_EN to enable leading-zero blanking.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 100000,
    parameter int unsigned GUARD    = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] data_in,
    input  logic        upd,
    output logic [3:0]  sm_wei,
    output logic [6:0]  sm_duan
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(SEG7_DIGITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] GUARD_C  = CW'(GUARD);
    localparam logic [IW-1:0] IDX_LAST = IW'(SEG7_DIGITS - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [15:0]   shadow_q, shadow_d;
    logic [15:0]   active_q, active_d;
    logic          pending_q, pending_d;
    logic [3:0]    wei_q, wei_d;
    logic [6:0]    duan_q, duan_d;

    phase_e        phase;
    logic          slot_end;
    logic          frame_end;
    logic [3:0]    nibble;
    logic [6:0]    hex_seg;
    logic [3:0]    lzb_mask;

    seg7_hex_decode u_dec (
        .nibble (nibble),
        .seg    (hex_seg)
    );

    // Slot phase, slot/frame ends and the nibble for the current digit
    always_comb begin
        phase     = (cnt_q < GUARD_C) ? PH_BLANK : PH_ON;
        slot_end  = (cnt_q == CNT_LAST);
        frame_end = slot_end && (idx_q == IDX_LAST);
        nibble    = active_q[{idx_q, 2'b00} +: 4];
    end

`ifdef SEG7_LZB_EN
    // Blank zero digits above the most significant nonzero one
    always_comb begin
        lzb_mask    = 4'b0000;
        lzb_mask[3] = (active_q[15:12] == 4'h0);
        lzb_mask[2] = lzb_mask[3] && (active_q[11:8] == 4'h0);
        lzb_mask[1] = lzb_mask[2] && (active_q[7:4] == 4'h0);
    end
`else
    // Every digit always shows its hex value
    always_comb begin
        lzb_mask = 4'b0000;
    end
`endif

    // Scan counters plus shadow/active handoff at the frame boundary
    always_comb begin
        cnt_d     = slot_end ? '0 : cnt_q + CW'(1);
        idx_d     = slot_end ? idx_q + IW'(1) : idx_q;
        shadow_d  = upd ? data_in : shadow_q;
        pending_d = upd ? 1'b1 : pending_q;
        active_d  = active_q;
        if (frame_end) begin
            if (upd) begin
                active_d  = data_in;
                pending_d = 1'b0;
            end else if (pending_q) begin
                active_d  = shadow_q;
                pending_d = 1'b0;
            end
        end
    end

    // Next pin values from this cycle's scan position and active data
    always_comb begin
        wei_d  = WEI_OFF;
        duan_d = SEG7_BLANK;
        if (phase == PH_ON) begin
            wei_d  = ~(4'b0001 << idx_q);
            duan_d = lzb_mask[idx_q] ? SEG7_BLANK : hex_seg;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            shadow_q  <= 16'h0000;
            active_q  <= 16'h0000;
            pending_q <= 1'b0;
            wei_q     <= WEI_OFF;
            duan_q    <= SEG7_BLANK;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            wei_q     <= wei_d;
            duan_q    <= duan_d;
        end
    end

    assign sm_wei  = wei_q;
    assign sm_duan = duan_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver (SCAN_DIV=8, GUARD=2).
// Reference model works from elapsed time and the latest update value.
module tb_seg7_scan_driver;

    localparam int SD = 8;
    localparam int GD = 2;
    localparam int FR = 4 * SD;

    logic        clk;
    logic        reset;
    logic [15:0] data_in;
    logic        upd;
    logic [3:0]  sm_wei;
    logic [6:0]  sm_duan;

    seg7_scan_driver #(
        .SCAN_DIV (SD),
        .GUARD    (GD)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .data_in (data_in),
        .upd     (upd),
        .sm_wei  (sm_wei),
        .sm_duan (sm_duan)
    );

    typedef struct {
        logic [3:0] w;
        logic [6:0] s;
        int         n;
    } exp_t;

    exp_t        q[$];
    logic [6:0]  hex_t [16];
    int          total;
    int          bad;
    int          ncyc;
    int          t;
    logic [15:0] latest;
    logic [15:0] shown;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] model_seg(input logic [15:0] v, input int dig);
        logic [15:0] above;
        above = v >> (4 * dig);
`ifdef SEG7_LZB_EN
        if (dig > 0 && above == 16'h0) return 7'h7F;
`endif
        return hex_t[above[3:0]];
    endfunction

    task automatic step(input logic r, input logic u, input logic [15:0] d);
        exp_t e;
        int   dig;
        @(negedge clk);
        reset   = r;
        upd     = u;
        data_in = d;
        if (r || (t % SD) < GD) begin
            e.w = 4'hF;
            e.s = 7'h7F;
        end else begin
            dig = (t / SD) % 4;
            e.w = ~(4'b0001 << dig);
            e.s = model_seg(shown, dig);
        end
        e.n = ncyc;
        ncyc++;
        q.push_back(e);
        if (r) begin
            t      = 0;
            latest = 16'h0;
            shown  = 16'h0;
        end else begin
            if (u) latest = d;
            if (t % FR == FR - 1) shown = latest;
            t++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic spot(input string name, input logic [3:0] w, input logic [6:0] s);
        total++;
        if (sm_wei !== w || sm_duan !== s) begin
            bad++;
            $display("FAIL %s: got wei=%h duan=%h need wei=%h duan=%h",
                     name, sm_wei, sm_duan, w, s);
        end
    endtask

    task automatic idle_until(input int m);
        int k;
        k = 0;
        while (t % FR != m && k < 2 * FR) begin
            step(1'b0, 1'b0, 16'h0);
            k++;
        end
    endtask

    task automatic seek(input int d, input int c);
        idle_until(d * SD + c);
        step(1'b0, 1'b0, 16'h0);
    endtask

    // Monitor: compare pins against the queued expectation each edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                total++;
                if (sm_wei !== e.w || sm_duan !== e.s) begin
                    bad++;
                    $display("FAIL pins@%0d: got wei=%h duan=%h need wei=%h duan=%h",
                             e.n, sm_wei, sm_duan, e.w, e.s);
                end
            end
        end
    end

    initial begin
        logic [15:0] d;
        logic        lz;
        hex_t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        total   = 0;
        bad     = 0;
        ncyc    = 0;
        t       = 0;
        latest  = 16'h0;
        shown   = 16'h0;
        reset   = 1'b1;
        upd     = 1'b0;
        data_in = 16'h0;
`ifdef SEG7_LZB_EN
        lz = 1'b1;
`else
        lz = 1'b0;
`endif

        // Reset and the first slots after release
        step(1'b1, 1'b0, 16'h0);
        spot("rst", 4'hF, 7'h7F);
        repeat (2) begin
            step(1'b0, 1'b0, 16'h0);
            spot("guard0", 4'hF, 7'h7F);
        end
        repeat (6) begin
            step(1'b0, 1'b0, 16'h0);
            spot("dig0_on", 4'hE, 7'h40);
        end
        repeat (2) begin
            step(1'b0, 1'b0, 16'h0);
            spot("guard1", 4'hF, 7'h7F);
        end
        step(1'b0, 1'b0, 16'h0);
        spot("dig1_on", 4'hD, 7'h40);

        // Update shown from the next frame
        step(1'b0, 1'b1, 16'h12AF);
        seek(0, 2); spot("12AF_d0", 4'hE, 7'h0E);
        seek(1, 2); spot("12AF_d1", 4'hD, 7'h08);
        seek(2, 2); spot("12AF_d2", 4'hB, 7'h24);
        seek(3, 2); spot("12AF_d3", 4'h7, 7'h79);

        // Mid-frame update must not tear the current frame
        seek(1, 3);
        step(1'b0, 1'b1, 16'h8888);
        seek(2, 2); spot("notear_d2", 4'hB, 7'h24);
        seek(3, 2); spot("notear_d3", 4'h7, 7'h79);
        seek(0, 2); spot("8888_d0", 4'hE, 7'h00);
        seek(3, 2); spot("8888_d3", 4'h7, 7'h00);

        // Update on the exact frame-boundary cycle
        idle_until(FR - 1);
        step(1'b0, 1'b1, 16'h0003);
        seek(0, 2); spot("bypass_d0", 4'hE, 7'h30);
        seek(1, 2); spot("bypass_d1", 4'hD, lz ? 7'h7F : 7'h40);
        seek(0, 3); spot("bypass_hold", 4'hE, 7'h30);

        // Reset in the middle of digit 2
        seek(2, 3);
        step(1'b1, 1'b0, 16'h0);
        spot("midrst", 4'hF, 7'h7F);
        step(1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b0, 16'h0);
        step(1'b0, 1'b0, 16'h0);
        spot("midrst_d0", 4'hE, 7'h40);

        // Leading-zero cases
        step(1'b0, 1'b1, 16'h0005);
        seek(0, 2); spot("0005_d0", 4'hE, 7'h12);
        seek(1, 2); spot("0005_d1", 4'hD, lz ? 7'h7F : 7'h40);
        seek(3, 2); spot("0005_d3", 4'h7, lz ? 7'h7F : 7'h40);
        step(1'b0, 1'b1, 16'h0000);
        seek(0, 2); spot("0000_d0", 4'hE, 7'h40);
        seek(2, 2); spot("0000_d2", 4'hB, lz ? 7'h7F : 7'h40);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            d = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 3)));
            if ($urandom_range(0, 399) == 0)
                step(1'b1, 1'b0, d);
            else
                step(1'b0, ($urandom_range(0, 4) == 0), d);
        end
        step(1'b0, 1'b0, 16'h0);
        upd = 1'b0;
        @(posedge clk);
        #2;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d left need 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
